// File: rtl/calendar_pkg.sv
// Shared definitions for the calendar setting front-end: field indices and
// the OFF/EDIT controller state type.
package calendar_pkg;

  localparam logic [2:0] FIELD_0    = 3'd0;
  localparam logic [2:0] FIELD_1    = 3'd1;
  localparam logic [2:0] FIELD_2    = 3'd2;
  localparam logic [2:0] FIELD_3    = 3'd3;
  localparam logic [2:0] FIELD_4    = 3'd4;
  localparam logic [2:0] FIELD_LAST = FIELD_4;

  typedef enum logic {
    ST_OFF,
    ST_EDIT
  } state_e;

  // Wraps after the last field so codes 5..7 can never appear.
  function automatic logic [2:0] next_field(input logic [2:0] f);
    return (f == FIELD_LAST) ? FIELD_0 : f + 3'd1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stable-count debounce for one raw push-button.
// level follows the synchronised input after DB_CYCLES differing samples; rise pulses once per press.
module btn_debounce #(
  parameter int unsigned DB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic rise
);

  localparam int unsigned CW = $clog2(DB_CYCLES + 1);

  logic          sync1_q;
  logic          sync2_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          level_q;
  logic          level_d;
  logic          level_dly_q;
  logic          rise_q;
  logic          rise_d;

  // Any cycle where the input agrees with the accepted level restarts the count.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DB_CYCLES - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    rise_d = level_q & ~level_dly_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      rise_q      <= 1'b0;
    end else begin
      sync1_q     <= btn_raw;
      sync2_q     <= sync1_q;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_q;
      rise_q      <= rise_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/mode_key_ctrl.sv
// Button front-end for the calendar setting path: debounced set/mode/key buttons
// driving an OFF/EDIT controller. Define MODE_KEY_AUTOREPEAT_EN for key auto-repeat.
module mode_key_ctrl
  import calendar_pkg::*;
#(
  parameter int unsigned DB_CYCLES     = 16,
  parameter int unsigned IDLE_CYCLES   = 1000,
  parameter int unsigned REPEAT_DELAY  = 500,
  parameter int unsigned REPEAT_PERIOD = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_btn,
  input  logic       mode_btn,
  input  logic       key_btn,
  output logic       key,
  output logic [2:0] mode,
  output logic       on_off
);

  localparam int unsigned IW = $clog2(IDLE_CYCLES + 1);

  logic set_ev;
  logic mode_ev;
  logic key_ev;
  logic key_lvl;
  logic set_lvl_unused;
  logic mode_lvl_unused;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_set (
    .clk(clk), .rst_n(rst_n), .btn_raw(set_btn), .level(set_lvl_unused), .rise(set_ev)
  );
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
    .clk(clk), .rst_n(rst_n), .btn_raw(mode_btn), .level(mode_lvl_unused), .rise(mode_ev)
  );
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_key (
    .clk(clk), .rst_n(rst_n), .btn_raw(key_btn), .level(key_lvl), .rise(key_ev)
  );

  state_e        state_q;
  state_e        state_d;
  logic [2:0]    mode_q;
  logic [2:0]    mode_d;
  logic          key_q;
  logic          key_d;
  logic [IW-1:0] idle_q;
  logic [IW-1:0] idle_d;
  logic          key_accept;
  logic          rpt_stop;
  logic          rpt_fire;

  // Priority set > mode > key > repeat > idle timeout; a lower event in the same cycle is dropped.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    key_d      = 1'b0;
    idle_d     = idle_q;
    key_accept = 1'b0;
    rpt_stop   = 1'b0;
    case (state_q)
      ST_OFF: begin
        idle_d   = '0;
        rpt_stop = 1'b1;
        if (set_ev) begin
          state_d = ST_EDIT;
          mode_d  = FIELD_0;
        end
      end
      ST_EDIT: begin
        if (set_ev) begin
          state_d  = ST_OFF;
          mode_d   = FIELD_0;
          idle_d   = '0;
          rpt_stop = 1'b1;
        end else if (mode_ev) begin
          mode_d   = next_field(mode_q);
          idle_d   = '0;
          rpt_stop = 1'b1;
        end else if (key_ev) begin
          key_d      = 1'b1;
          idle_d     = '0;
          key_accept = 1'b1;
        end else if (rpt_fire) begin
          key_d  = 1'b1;
          idle_d = '0;
        end else if (idle_q == IW'(IDLE_CYCLES - 1)) begin
          state_d  = ST_OFF;
          mode_d   = FIELD_0;
          idle_d   = '0;
          rpt_stop = 1'b1;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_OFF;
        mode_d  = FIELD_0;
        idle_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_OFF;
      mode_q  <= FIELD_0;
      key_q   <= 1'b0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      key_q   <= key_d;
      idle_q  <= idle_d;
    end
  end

`ifdef MODE_KEY_AUTOREPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW      = $clog2(RPT_MAX + 1);

  logic          rpt_on_q;
  logic          rpt_on_d;
  logic [RW-1:0] rpt_cnt_q;
  logic [RW-1:0] rpt_cnt_d;

  always_comb begin
    rpt_fire = rpt_on_q & key_lvl & (rpt_cnt_q == '0) & (state_q == ST_EDIT);
  end

  // Down-counter: loaded with DELAY-1 at the press pulse, reloaded with PERIOD-1 on each repeat.
  always_comb begin
    rpt_on_d  = rpt_on_q;
    rpt_cnt_d = rpt_cnt_q;
    if (rpt_on_q) begin
      rpt_cnt_d = (rpt_cnt_q == '0) ? RW'(REPEAT_PERIOD - 1) : rpt_cnt_q - 1'b1;
    end
    if (key_accept) begin
      rpt_on_d  = 1'b1;
      rpt_cnt_d = RW'(REPEAT_DELAY - 1);
    end
    if (rpt_stop || !key_lvl) begin
      rpt_on_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_on_q  <= 1'b0;
      rpt_cnt_q <= '0;
    end else begin
      rpt_on_q  <= rpt_on_d;
      rpt_cnt_q <= rpt_cnt_d;
    end
  end
`else
  localparam int unsigned RPT_CFG_UNUSED = REPEAT_DELAY + REPEAT_PERIOD;
  logic key_lvl_unused;
  logic rpt_stop_unused;
  logic key_accept_unused;

  always_comb begin
    rpt_fire          = 1'b0;
    key_lvl_unused    = key_lvl;
    rpt_stop_unused   = rpt_stop;
    key_accept_unused = key_accept;
  end
`endif

  assign key    = key_q;
  assign mode   = mode_q;
  assign on_off = (state_q == ST_EDIT);

endmodule

// File: tb/tb_mode_key_ctrl.sv
// Scoreboard bench for mode_key_ctrl: a window-based debounce and event-level
// controller model predicts each output presentation; a monitor compares them.
module tb_mode_key_ctrl;

  localparam int DB   = 4;
  localparam int IDLE = 100;
  localparam int RD   = 20;
  localparam int RP   = 5;
  localparam int NMAX = 8000;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       set_btn  = 1'b0;
  logic       mode_btn = 1'b0;
  logic       key_btn  = 1'b0;
  logic       key;
  logic [2:0] mode;
  logic       on_off;

  mode_key_ctrl #(
    .DB_CYCLES(DB), .IDLE_CYCLES(IDLE), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .set_btn(set_btn), .mode_btn(mode_btn), .key_btn(key_btn),
    .key(key), .mode(mode), .on_off(on_off)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int cyc;
    bit key;
    int mode;
    bit on;
  } rec_t;
  rec_t exp_q[$];

  // Reference state: raw samples and accepted levels per edge, plus controller view.
  bit raw_h [3][NMAX];
  bit lvl_h [3][NMAX];
  bit m_edit, m_key, m_rpt;
  int m_mode, last_act, kp;
  int pushed_at = -1;

  function automatic void model_clear();
    for (int b = 0; b < 3; b++)
      for (int i = 0; i < NMAX; i++) begin
        raw_h[b][i] = 1'b0;
        lvl_h[b][i] = 1'b0;
      end
    m_edit = 0; m_key = 0; m_rpt = 0; m_mode = 0; last_act = 0; kp = 0;
  endfunction

  function automatic bit samp(int b, int i);
    return (i >= 0) ? raw_h[b][i] : 1'b0;
  endfunction

  // Outputs after edge c. Raw sampled at edge i reaches the debouncer at edge i+2;
  // the level flips once DB consecutive samples disagree; an event acts two edges later.
  function automatic void model_edge(int c, bit s, bit m, bit k);
    bit ev [3];
    bit klvl, pe;
    int pm;
    raw_h[0][c] = s; raw_h[1][c] = m; raw_h[2][c] = k;
    for (int b = 0; b < 3; b++) begin
      bit cur, flip;
      cur  = lvl_h[b][c-1];
      flip = 1'b1;
      for (int j = 0; j < DB; j++) if (samp(b, c - 2 - j) == cur) flip = 1'b0;
      lvl_h[b][c] = flip ? !cur : cur;
      ev[b] = (c >= 3) && lvl_h[b][c-2] && !lvl_h[b][c-3];
    end
    klvl = lvl_h[2][c-1];
    pm = m_mode; pe = m_edit; m_key = 0;
    if (!m_edit) begin
      if (ev[0]) begin m_edit = 1; m_mode = 0; last_act = c; m_rpt = 0; end
    end else if (ev[0]) begin
      m_edit = 0; m_mode = 0; m_rpt = 0;
    end else if (ev[1]) begin
      m_mode = (m_mode + 1) % 5; last_act = c; m_rpt = 0;
    end else if (ev[2]) begin
      m_key = 1; last_act = c;
`ifdef MODE_KEY_AUTOREPEAT_EN
      m_rpt = 1; kp = c;
`endif
    end else if (m_rpt && klvl && (c - kp) >= RD && ((c - kp - RD) % RP) == 0) begin
      m_key = 1; last_act = c;
    end else if (c - last_act == IDLE) begin
      m_edit = 0; m_mode = 0; m_rpt = 0;
    end
    if (!klvl) m_rpt = 0;
    if (m_key || m_mode != pm || m_edit != pe) begin
      exp_q.push_back('{c, m_key, m_mode, m_edit});
      pushed_at = c;
    end
  endfunction

  task automatic step(input bit s, input bit m, input bit k);
    int c;
    set_btn = s; mode_btn = m; key_btn = k;
    c = edge_n + 1;
    if (c >= NMAX) begin
      $display("FAIL model_range cycle=%0d required below %0d", c, NMAX);
      $fatal(1);
    end
    model_edge(c, s, m, k);
    @(posedge clk); #1;
  endtask

  task automatic drive(input bit [2:0] v, input int n);
    repeat (n) step(v[2], v[1], v[0]);
  endtask

  task automatic do_reset(input bit [2:0] v, input int n);
    int guard = 0;
    while (pushed_at == edge_n && guard < 20) begin
      step(v[2], v[1], v[0]);
      guard++;
    end
    if (m_mode != 0 || m_edit) exp_q.push_back('{edge_n, 1'b0, 0, 1'b0});
    set_btn = v[2]; mode_btn = v[1]; key_btn = v[0];
    rst_n = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
    model_clear();
    rst_n = 1'b1;
  endtask

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d", nm, got, want);
    end
  endtask

  // Monitor: an output is presented when key is high or mode/on_off changed.
  int mon_pm = 0;
  int mon_po = 0;
  initial begin
    rec_t r;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc < edge_n) begin
        r = exp_q.pop_front();
        checks++; errors++;
        $display("FAIL missing_out cyc=%0d got no output, required key=%0b mode=%0d on_off=%0b",
                 r.cyc, r.key, r.mode, r.on);
      end
      if (key === 1'b1 || int'(mode) != mon_pm || int'(on_off) != mon_po) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out cyc=%0d got key=%0b mode=%0d on_off=%0b, required no change",
                   edge_n, key, mode, on_off);
        end else begin
          r = exp_q.pop_front();
          if (r.cyc != edge_n || r.key != key || r.mode != int'(mode) || r.on != on_off) begin
            errors++;
            $display("FAIL out_check got cyc=%0d key=%0b mode=%0d on_off=%0b required cyc=%0d key=%0b mode=%0d on_off=%0b",
                     edge_n, key, mode, on_off, r.cyc, r.key, r.mode, r.on);
          end
        end
      end
      mon_pm = int'(mode);
      mon_po = int'(on_off);
    end
  end

  initial begin
    bit cur [3];
    int hold [3];
    rec_t r;
    model_clear();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_key", int'(key), 0);
    chk("rst_mode", int'(mode), 0);
    chk("rst_on_off", int'(on_off), 0);

    drive(3'b000, 50);
    drive(3'b100, 10); drive(3'b000, 10);
    repeat (5) begin drive(3'b010, 8); drive(3'b000, 8); end
    repeat (4) begin drive(3'b001, 3); drive(3'b000, 1); end
    drive(3'b001, 10); drive(3'b000, 12);
    drive(3'b011, 8);  drive(3'b000, 10);
    drive(3'b000, 110);
    drive(3'b100, 8);  drive(3'b000, 8);
    drive(3'b010, 8);  drive(3'b000, 8);
    drive(3'b110, 8);  drive(3'b000, 10);
    drive(3'b001, 10); drive(3'b000, 10);
    drive(3'b100, 8);  drive(3'b000, 82);
    drive(3'b001, 8);  drive(3'b000, 120);
    drive(3'b100, 8);  drive(3'b000, 8);
    drive(3'b001, 57); drive(3'b000, 30);
    drive(3'b100, 8);  drive(3'b000, 10);
    drive(3'b100, 8);  drive(3'b000, 10);
    drive(3'b010, 8);  drive(3'b000, 4);
    drive(3'b100, 2);
    do_reset(3'b100, 3);
    drive(3'b100, 10); drive(3'b000, 20);

    for (int b = 0; b < 3; b++) begin cur[b] = 1'b0; hold[b] = 0; end
    for (int i = 0; i < 1500; i++) begin
      for (int b = 0; b < 3; b++) begin
        if (hold[b] == 0) begin
          cur[b] = !cur[b];
          hold[b] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(30, 60)) : int'($urandom_range(1, 10));
          if (!cur[b] && b == 0) hold[b] += int'($urandom_range(20, 120));
        end
        hold[b]--;
      end
      if (i == 700) do_reset({cur[0], cur[1], cur[2]}, 2);
      step(cur[0], cur[1], cur[2]);
    end

    drive(3'b000, 130);
    @(negedge clk);
    @(negedge clk);
    while (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      checks++; errors++;
      $display("FAIL leftover_out cyc=%0d got no output, required key=%0b mode=%0d on_off=%0b",
               r.cyc, r.key, r.mode, r.on);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mode_key_ctrl.md
# mode_key_ctrl

Front-end button controller for the calendar setting path; it produces the `key`, `mode[2:0]` and `on_off` signals consumed by the 1-to-5 key/select demultiplexer. It synchronises and debounces three raw push-buttons and runs an OFF/EDIT state machine. In EDIT, the mode button cycles the target field 0→4 and the key button issues single-cycle increment pulses, so each press is routed to exactly one field.

## Interface
- `DB_CYCLES`, 16, consecutive stable cycles required to accept a button level change (≥1)
- `IDLE_CYCLES`, 1000, cycles in EDIT without any accepted press before automatic return to OFF (≥1)
- `REPEAT_DELAY`, 500, cycles from a key press pulse to the first auto-repeat pulse (used only with `MODE_KEY_AUTOREPEAT_EN`)
- `REPEAT_PERIOD`, 100, cycles between subsequent auto-repeat pulses (used only with `MODE_KEY_AUTOREPEAT_EN`)
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous, active-low reset
- `set_btn`  in  1  raw, asynchronous, active-high; toggles OFF/EDIT
- `mode_btn`  in  1  raw, asynchronous, active-high; advances the field
- `key_btn`  in  1  raw, asynchronous, active-high; increments the selected field
- `key`  out  1  registered single-cycle increment pulse
- `mode`  out  3  registered selected field, 0..4
- `on_off`  out  1  registered; 1 in EDIT, 0 in OFF

## Operation
- Per button: 2-flop synchroniser, then debounce. The debounced level flips only after the synchronised input has differed from it for `DB_CYCLES` consecutive cycles. Any mismatch gap restarts the count.
- A press event is the rising edge of the debounced level, lasting one cycle. Releases generate no events.
- FSM states:
  - OFF: `on_off`=0, `mode`=0, `key`=0.
  - EDIT: `on_off`=1.
- OFF→EDIT on a set press; `mode` loads 0.
- EDIT→OFF on a set press or on idle timeout; `mode` clears to 0.
- In OFF, mode and key presses are ignored.
- EDIT, mode press: `mode` = (`mode`==4) ? 0 : `mode`+1. Values 5–7 are never produced.
- EDIT, key press: `key`=1 for one cycle.
- Simultaneous events in one cycle:
  - set beats mode and key; those events are dropped.
  - mode beats key; key is dropped, so no pulse goes to a stale field.
- Idle counter:
  - Cleared on entry to EDIT and on every accepted press event, including auto-repeat pulses.
  - When it reaches `IDLE_CYCLES`-1 with no event, the FSM goes to OFF on the next edge.
  - Held at 0 while in OFF.
- Reset mid-operation: all synchronisers, debounce counters, debounced levels, idle and repeat counters clear. A button held through reset release must be re-accepted through the full debounce, and then yields a press event.

## Timing
- Reset values: `key`=0, `mode`=3'd0, `on_off`=0; FSM in OFF.
- Press latency: raw input first sampled high at edge 0 → output effect registered at edge `DB_CYCLES`+3. This applies to the `key` pulse, the `mode` change and the `on_off` change.
- `key` is never high for two consecutive cycles. The minimum spacing between repeat pulses is `REPEAT_PERIOD` cycles.
- `mode` and `on_off` change only on press/timeout edges and are glitch-free (registered).

## Configuration
- `MODE_KEY_AUTOREPEAT_EN` defined:
  - While the debounced `key_btn` stays high in EDIT, an extra `key` pulse is issued `REPEAT_DELAY` cycles after the press pulse, then every `REPEAT_PERIOD` cycles.
  - Repeating stops within one cycle when the level is released, on a mode press, or on leaving EDIT.
- Not defined: exactly one `key` pulse per press. The repeat counter and the `REPEAT_*` logic are absent.

## Structure
- Shared package `calendar_pkg`:
  - Field constants `FIELD_0`..`FIELD_4`, with `FIELD_LAST`=3'd4.
  - FSM state typedef {`ST_OFF`, `ST_EDIT`}.
- Sub-module `btn_debounce` (synchroniser, counter, level output, rise pulse output), instantiated three times.

## Test plan
Bench parameters: `DB_CYCLES`=4, `IDLE_CYCLES`=100, `REPEAT_DELAY`=20, `REPEAT_PERIOD`=5.
- Reset, then idle 50 cycles → `on_off`=0, `mode`=0, `key`=0 throughout.
- Set press held for 10 cycles → `on_off`=1 exactly 7 edges after the first high sample. Five mode presses → `mode` goes 1,2,3,4,0.
- `key_btn` bouncing (high 3 cycles / low 1, repeated), then stable high for 10 cycles → exactly one `key` pulse. Key press while OFF → no pulse.
- Mode and key debounced in the same cycle in EDIT → `mode` advances, no `key` pulse. Set and mode in the same cycle → OFF with `mode`=0.
- Enter EDIT, then no presses → `on_off` falls 100 cycles after entry. A key press at cycle 90 postpones the fall to 100 cycles after that press.
- With `MODE_KEY_AUTOREPEAT_EN`, `key_btn` held for 50 cycles after acceptance → pulses at +0, +20, +25, +30, …, +45, and none after release. Without the macro → one pulse only.
